mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, the number of ACCESS cycles without dddr_resp before the access aborts; legal range 2..65535.
REQ-002 Parameter ZERO_RD_ON_ERR, default 1, when 1 forces rd_data=0 on any errored load.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 stall  in  1  downstream hold; the mem_wb outputs freeze and no new op is accepted.
REQ-006 ex_mem_cword  in  rvga_cword  op from execute; uses fields imm, rs1_data, rs2_data, dddr_read, dddr_write, dwidth.
REQ-007 ex_mem_valid  in  1  ex_mem_cword is valid.
REQ-008 ld_unsigned  in  1  load zero-extends when 1 and sign-extends when 0; sampled with ex_mem_cword.
REQ-009 ex_mem_ready  out  1  op accepted this cycle when ex_mem_valid=1.
REQ-010 dddr_addr  out  rvga_word  byte address, imm+rs1_data modulo 2^32.
REQ-011 dddr_read / dddr_write  out  1 each  request strobes, mutually exclusive.
REQ-012 dddr_wdata  out  rvga_word  store data, lane-replicated.
REQ-013 dddr_byteen  out  4  store byte enables; 0 during loads.
REQ-014 dddr_rdata  in  rvga_word  load data, valid when dddr_resp=1.
REQ-015 dddr_resp  in  1  completes the current access.
REQ-016 mem_wb_cword  out  rvga_cword  result to writeback.
REQ-017 mem_wb_valid  out  1  mem_wb_cword is valid.
REQ-018 mem_err  out  2  error code qualified by mem_wb_valid: 0 none, 1 timeout, 2 misaligned.

Function
REQ-019 FSM states: IDLE and ACCESS.
REQ-020 ex_mem_ready = (state==IDLE) & ~stall & ~rst.
REQ-021 An accepted op with neither dddr_read nor dddr_write: on the next edge mem_wb_cword=ex_mem_cword, mem_wb_valid=1 and mem_err=0 (latency 1).
REQ-022 An accepted memory op registers the address, data, byte enables, width and ld_unsigned, then enters ACCESS; dddr_read/dddr_write are high from the next cycle until and including the cycle dddr_resp=1.
REQ-023 In ACCESS, dddr_addr, dddr_wdata and dddr_byteen hold constant; ex_mem_cword changes have no effect.
REQ-024 Load lane select: shifted = dddr_rdata >> (8*addr[1:0]); byte uses shifted[7:0], half uses shifted[15:0], word uses all 32 bits.
REQ-025 Load extension: byte and half are sign-extended when ld_unsigned=0 and zero-extended when ld_unsigned=1.
REQ-026 Store data: byte uses {4{rs2[7:0]}}, half uses {2{rs2[15:0]}}, word uses rs2.
REQ-027 Store byte enables: byte uses 4'b0001<<addr[1:0], half uses 4'b0011<<(2*addr[1]), word uses 4'b1111.
REQ-028 On dddr_resp in ACCESS, mem_wb_cword takes the registered cword with rd_data replaced on loads, mem_wb_valid=1, and the FSM returns to IDLE on the same edge.
REQ-029 The timeout counter clears on ACCESS entry and increments each ACCESS cycle without dddr_resp.
REQ-030 When the counter reaches TIMEOUT_CYCLES: strobes drop, mem_err=1, mem_wb_valid=1, and the FSM returns to IDLE.
REQ-031 When dddr_resp and timeout occur in the same cycle, the response wins and mem_err=0.
REQ-032 When stall=1 at resp or timeout, the result is captured into a one-entry skid register and presented once stall=0; the FSM holds in IDLE with ex_mem_ready=0 until the skid drains.
REQ-033 When stall=1 with no pending result, mem_wb_* hold their values.
REQ-034 When stall=0 and no result is produced, mem_wb_valid=0 on the next edge.
REQ-035 dddr_resp while in IDLE is ignored.

Reset
REQ-036 rst=1 immediately forces: state IDLE, dddr_read=0, dddr_write=0, dddr_addr=0, dddr_wdata=0, dddr_byteen=0, mem_wb_cword=0, mem_wb_valid=0, mem_err=0, timeout counter 0, skid register empty.
REQ-037 Reset during ACCESS abandons the access with no writeback; a dddr_resp arriving after reset is ignored.

Configuration
REQ-038 Macro RVGA_MEM_MISALIGN_TRAP_EN.
REQ-039 With RVGA_MEM_MISALIGN_TRAP_EN defined, a half op with addr[0]=1 or a word op with addr[1:0]!=0 issues no bus strobe and produces, one cycle after acceptance, mem_wb_valid=1 and mem_err=2, with rd_data=0 when ZERO_RD_ON_ERR=1.
REQ-040 Without RVGA_MEM_MISALIGN_TRAP_EN, misaligned ops issue normally with the raw address and mem_err never equals 2.

Verification
REQ-041 LB with rs1=0x100, imm=3, ld_unsigned=0, rdata=0x80FFFFFF and resp after 2 cycles -> dddr_addr=0x103, rd_data=0xFFFFFF80, mem_wb_valid=1 for 1 cycle.
REQ-042 SH with addr 0x202 and rs2=0x1234ABCD -> dddr_byteen=4'b1100, dddr_wdata=0xABCDABCD, dddr_write high until resp.
REQ-043 LW with no resp and TIMEOUT_CYCLES=4 -> strobe high exactly 4 cycles, then mem_err=1, mem_wb_valid=1.
REQ-044 Resp arrives while stall=1 for 3 cycles -> ex_mem_ready=0 throughout; result appears with mem_wb_valid=1 the cycle after stall drops.
REQ-045 rst asserted mid-ACCESS, then resp the next cycle -> strobes 0 immediately, no mem_wb_valid, state IDLE.
REQ-046 LW to 0x101 with the macro defined -> no dddr_read, mem_err=2, rd_data=0; without the macro -> dddr_addr=0x101 issued.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit: one outstanding data-bus access, with a timeout and a one-entry skid for stalled results.
// Build option: define RVGA_MEM_MISALIGN_TRAP_EN to trap misaligned half/word ops instead of issuing them.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter bit ZERO_RD_ON_ERR = 1'b1,
    localparam int CW_W = 132
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [CW_W-1:0] ex_mem_cword,
    input  logic            ex_mem_valid,
    input  logic            ld_unsigned,
    output logic            ex_mem_ready,
    output logic [31:0]     dddr_addr,
    output logic            dddr_read,
    output logic            dddr_write,
    output logic [31:0]     dddr_wdata,
    output logic [3:0]      dddr_byteen,
    input  logic [31:0]     dddr_rdata,
    input  logic            dddr_resp,
    output logic [CW_W-1:0] mem_wb_cword,
    output logic            mem_wb_valid,
    output logic [1:0]      mem_err
);

    // cword layout: [31:0] imm, [63:32] rs1_data, [95:64] rs2_data, [127:96] rd_data,
    // [128] dddr_read, [129] dddr_write, [131:130] dwidth (0 byte, 1 half, 2/3 word)
    localparam logic [1:0] W_BYTE   = 2'd0;
    localparam logic [1:0] W_HALF   = 2'd1;
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_TMO  = 2'd1;
    localparam logic [1:0] ERR_MIS  = 2'd2;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state_reg, state_next;

    logic [31:0]     op_imm, op_rs1, op_rs2, acc_addr;
    logic            op_read, op_write, op_is_mem, op_store;
    logic [1:0]      op_width;
    logic [31:0]     st_wdata;
    logic [3:0]      st_byteen;
    logic            trap;
    logic            accept, accept_mem, accept_pass, accept_trap;
    logic            resp_done, tmo_hit;

    logic [1:0]      width_reg;
    logic            uns_reg, is_rd_reg, is_wr_reg;
    logic [CW_W-1:0] cword_reg;
    logic [15:0]     tmo_cnt_reg;

    logic [31:0]     ld_shifted, ld_data;
    logic            res_valid;
    logic [CW_W-1:0] res_cword;
    logic [1:0]      res_err;

    logic            skid_valid_reg;
    logic [CW_W-1:0] skid_cword_reg;
    logic [1:0]      skid_err_reg;

    assign op_imm    = ex_mem_cword[31:0];
    assign op_rs1    = ex_mem_cword[63:32];
    assign op_rs2    = ex_mem_cword[95:64];
    assign op_read   = ex_mem_cword[128];
    assign op_write  = ex_mem_cword[129];
    assign op_width  = ex_mem_cword[131:130];
    assign op_is_mem = op_read | op_write;
    assign op_store  = op_write & ~op_read;
    assign acc_addr  = op_imm + op_rs1;

    // Per-lane store data replication and byte-enable decode.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign st_wdata[8*gi +: 8] = (op_width == W_BYTE) ? op_rs2[7:0] :
                                         (op_width == W_HALF) ? op_rs2[8*(gi%2) +: 8] :
                                                                op_rs2[8*gi +: 8];
            assign st_byteen[gi] = (op_width == W_BYTE) ? (acc_addr[1:0] == 2'(gi)) :
                                   (op_width == W_HALF) ? (acc_addr[1] == (gi >= 2)) :
                                                          1'b1;
        end
    endgenerate

`ifdef RVGA_MEM_MISALIGN_TRAP_EN
    assign trap = op_is_mem & (((op_width == W_HALF) & acc_addr[0]) |
                               (op_width[1] & (acc_addr[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    assign accept      = ex_mem_ready & ex_mem_valid;
    assign accept_mem  = accept & op_is_mem & ~trap;
    assign accept_trap = accept & op_is_mem & trap;
    assign accept_pass = accept & ~op_is_mem;
    assign resp_done   = (state_reg == ACCESS) & dddr_resp;
    assign tmo_hit     = (state_reg == ACCESS) & ~dddr_resp & (tmo_cnt_reg == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept_mem) state_next = ACCESS;
            ACCESS:  if (resp_done || tmo_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes stay up through the response cycle and fall with the timeout edge.
    always_comb begin
        ex_mem_ready = (state_reg == IDLE) & ~stall & ~rst & ~skid_valid_reg;
        dddr_read    = (state_reg == ACCESS) & is_rd_reg;
        dddr_write   = (state_reg == ACCESS) & is_wr_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dddr_addr   <= '0;
            dddr_wdata  <= '0;
            dddr_byteen <= '0;
            width_reg   <= '0;
            uns_reg     <= 1'b0;
            is_rd_reg   <= 1'b0;
            is_wr_reg   <= 1'b0;
            cword_reg   <= '0;
            tmo_cnt_reg <= '0;
        end else if (accept_mem) begin
            dddr_addr   <= acc_addr;
            dddr_wdata  <= st_wdata;
            dddr_byteen <= op_store ? st_byteen : 4'b0000;
            width_reg   <= op_width;
            uns_reg     <= ld_unsigned;
            is_rd_reg   <= op_read;
            is_wr_reg   <= op_store;
            cword_reg   <= ex_mem_cword;
            tmo_cnt_reg <= '0;
        end else if (state_reg == ACCESS && !dddr_resp && !tmo_hit) begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
        end
    end

    assign ld_shifted = dddr_rdata >> {addr_lsb(dddr_addr), 3'b000};

    function automatic logic [1:0] addr_lsb(input logic [31:0] a);
        return a[1:0];
    endfunction

    always_comb begin
        case (width_reg)
            W_BYTE:  ld_data = {{24{~uns_reg & ld_shifted[7]}}, ld_shifted[7:0]};
            W_HALF:  ld_data = {{16{~uns_reg & ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

    always_comb begin
        res_valid = 1'b0;
        res_cword = cword_reg;
        res_err   = ERR_NONE;
        if (accept_pass) begin
            res_valid = 1'b1;
            res_cword = ex_mem_cword;
        end else if (accept_trap) begin
            res_valid = 1'b1;
            res_cword = ex_mem_cword;
            res_err   = ERR_MIS;
            if (op_read && ZERO_RD_ON_ERR) res_cword[127:96] = '0;
        end else if (resp_done) begin
            res_valid = 1'b1;
            if (is_rd_reg) res_cword[127:96] = ld_data;
        end else if (tmo_hit) begin
            res_valid = 1'b1;
            res_err   = ERR_TMO;
            if (is_rd_reg && ZERO_RD_ON_ERR) res_cword[127:96] = '0;
        end
    end

    // A result produced under stall parks in the skid; ready stays low until it drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_cword   <= '0;
            mem_wb_valid   <= 1'b0;
            mem_err        <= ERR_NONE;
            skid_valid_reg <= 1'b0;
            skid_cword_reg <= '0;
            skid_err_reg   <= ERR_NONE;
        end else if (!stall) begin
            if (skid_valid_reg) begin
                mem_wb_cword   <= skid_cword_reg;
                mem_err        <= skid_err_reg;
                mem_wb_valid   <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else if (res_valid) begin
                mem_wb_cword <= res_cword;
                mem_err      <= res_err;
                mem_wb_valid <= 1'b1;
            end else begin
                mem_wb_valid <= 1'b0;
            end
        end else if (res_valid) begin
            skid_cword_reg <= res_cword;
            skid_err_reg   <= res_err;
            skid_valid_reg <= 1'b1;
        end
    end

endmodule
